// File: rtl/text_cursor_writer_pkg.sv
// text_cursor_writer_pkg
// Shared definitions for the text cursor writer: default plane geometry,
// control-code values, default blank/cursor glyph IDs, the writer FSM state
// enum and the cursor-position operation codes.
package text_cursor_writer_pkg;

  // Plane geometry defaults
  localparam int DEF_ROW_NUMBER     = 15;
  localparam int DEF_COL_NUMBER     = 40;
  localparam int DEF_CHAR_ID_LENGTH = 8;
  localparam int DEF_ROW_BIT_LEN    = 4;
  localparam int DEF_COL_BIT_LEN    = 6;

  // Glyph IDs
  localparam int DEF_BLANK_CHAR  = 0;
  localparam int DEF_CURSOR_CHAR = 129;

  // Control codes recognised in the byte stream
  localparam logic [7:0] CODE_LF = 8'h0A;  // newline
  localparam logic [7:0] CODE_CR = 8'h0D;  // carriage return
  localparam logic [7:0] CODE_BS = 8'h08;  // backspace
  localparam logic [7:0] CODE_FF = 8'h0C;  // form feed (clear screen)

  typedef enum logic [2:0] {
    INIT, IDLE, WRITE, ERASE, MOVE, SCROLL, CLEAR, DRAW
  } state_t;

  // Operations on the cursor position registers
  typedef enum logic [2:0] {
    POS_HOLD, POS_ADVANCE, POS_RETREAT, POS_HOME_COL, POS_HOME_ALL, POS_NEXT_LINE
  } pos_op_t;

  // Command class of an accepted byte
  typedef enum logic [2:0] {
    CMD_PRINT, CMD_LF, CMD_CR, CMD_BS, CMD_FF
  } cmd_t;

  // Classify a byte; caller zero-extends the character ID to 32 bits.
  function automatic cmd_t decode_byte(input logic [31:0] b);
    if (b == 32'(CODE_LF)) return CMD_LF;
    if (b == 32'(CODE_CR)) return CMD_CR;
    if (b == 32'(CODE_BS)) return CMD_BS;
    if (b == 32'(CODE_FF)) return CMD_FF;
    return CMD_PRINT;
  endfunction

endpackage

// File: rtl/text_cursor_writer_if.sv
// text_cursor_writer_if
// Bundles the byte-stream handshake (char_in/char_valid/char_ready), the
// character-plane write port (wr_data/wr_row/wr_col/wr_en/wr_push_up) and the
// cursor position report (cursor_row/cursor_col).
//   slave  : the writer (consumes bytes, drives the write port)
//   master : the byte source / plane side
interface text_cursor_writer_if
  import text_cursor_writer_pkg::*;
#(
  parameter int CHAR_ID_LENGTH = DEF_CHAR_ID_LENGTH,
  parameter int ROW_BIT_LEN    = DEF_ROW_BIT_LEN,
  parameter int COL_BIT_LEN    = DEF_COL_BIT_LEN
) ();

  logic [CHAR_ID_LENGTH-1:0] char_in;
  logic                      char_valid;
  logic                      char_ready;
  logic [CHAR_ID_LENGTH-1:0] wr_data;
  logic [ROW_BIT_LEN-1:0]    wr_row;
  logic [COL_BIT_LEN-1:0]    wr_col;
  logic                      wr_en;
  logic                      wr_push_up;
  logic [ROW_BIT_LEN-1:0]    cursor_row;
  logic [COL_BIT_LEN-1:0]    cursor_col;

  modport slave (
    input  char_in, char_valid,
    output char_ready, wr_data, wr_row, wr_col, wr_en, wr_push_up,
           cursor_row, cursor_col
  );

  modport master (
    output char_in, char_valid,
    input  char_ready, wr_data, wr_row, wr_col, wr_en, wr_push_up,
           cursor_row, cursor_col
  );

endinterface

// File: rtl/text_cursor_pos.sv
// text_cursor_pos
// Cursor row/column registers. One operation per cycle:
//   advance   : col+1, wrapping to col 0 of the next row
//   retreat   : col-1, wrapping to the last col of the previous row; holds at (0,0)
//   home-col  : col <- 0
//   home-all  : (0,0)
//   next-line : col <- 0, row+1
// The row never passes the last row; scrolling is the caller's job.
// Ports: clock, reset (async, active-high), op, row, col,
//        last_row, last_col, at_origin (status flags).
module text_cursor_pos
  import text_cursor_writer_pkg::*;
#(
  parameter int ROW_NUMBER  = DEF_ROW_NUMBER,
  parameter int COL_NUMBER  = DEF_COL_NUMBER,
  parameter int ROW_BIT_LEN = DEF_ROW_BIT_LEN,
  parameter int COL_BIT_LEN = DEF_COL_BIT_LEN
) (
  input  logic                   clock,
  input  logic                   reset,
  input  pos_op_t                op,
  output logic [ROW_BIT_LEN-1:0] row,
  output logic [COL_BIT_LEN-1:0] col,
  output logic                   last_row,
  output logic                   last_col,
  output logic                   at_origin
);

  localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);

  assign last_row  = (row == ROW_LAST);
  assign last_col  = (col == COL_LAST);
  assign at_origin = (row == '0) && (col == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else begin
      case (op)
        POS_ADVANCE: begin
          if (last_col) begin
            col <= '0;
            if (!last_row) row <= row + ROW_BIT_LEN'(1);
          end else begin
            col <= col + COL_BIT_LEN'(1);
          end
        end
        POS_RETREAT: begin
          if (col != '0) begin
            col <= col - COL_BIT_LEN'(1);
          end else if (row != '0) begin
            row <= row - ROW_BIT_LEN'(1);
            col <= COL_LAST;
          end
        end
        POS_HOME_COL: col <= '0;
        POS_HOME_ALL: begin
          row <= '0;
          col <= '0;
        end
        POS_NEXT_LINE: begin
          col <= '0;
          if (!last_row) row <= row + ROW_BIT_LEN'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_cursor_writer.sv
// text_cursor_writer
// Converts a byte stream of character IDs and control codes into single-cycle
// write / scroll / clear commands for the character plane, and owns the text
// cursor (wrap, newline, return, backspace, scroll, clear-screen).
// Ports:
//   clock, reset      : single clock, asynchronous active-high reset
//   bus (slave)       : char_in/char_valid/char_ready byte handshake,
//                       wr_data/wr_row/wr_col/wr_en/wr_push_up plane port,
//                       cursor_row/cursor_col current cursor position
// Build option:
//   CURSOR_EN : when defined, a cursor glyph is drawn at the cursor position;
//               moves erase the old cell first and DRAW the glyph afterwards.
// All plane outputs are decoded from registered state, so an async reset
// silences the write port immediately.
module text_cursor_writer
  import text_cursor_writer_pkg::*;
#(
  parameter int ROW_NUMBER     = DEF_ROW_NUMBER,
  parameter int COL_NUMBER     = DEF_COL_NUMBER,
  parameter int CHAR_ID_LENGTH = DEF_CHAR_ID_LENGTH,
  parameter int ROW_BIT_LEN    = DEF_ROW_BIT_LEN,
  parameter int COL_BIT_LEN    = DEF_COL_BIT_LEN,
  parameter int BLANK_CHAR     = DEF_BLANK_CHAR,
  parameter int CURSOR_CHAR    = DEF_CURSOR_CHAR
) (
  input  logic                 clock,
  input  logic                 reset,
  text_cursor_writer_if.slave  bus
);

`ifdef CURSOR_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  localparam logic [ROW_BIT_LEN-1:0]    ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]    COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [CHAR_ID_LENGTH-1:0] BLANK    = CHAR_ID_LENGTH'(BLANK_CHAR);
  localparam logic [CHAR_ID_LENGTH-1:0] GLYPH    = CHAR_ID_LENGTH'(CURSOR_CHAR);
  // Where every command lands once the cursor is settled
  localparam state_t SETTLE = CURSOR_ON ? DRAW : IDLE;
  // First step of a command that moves the cursor without writing its cell
  localparam state_t MOVE_ENTRY = CURSOR_ON ? ERASE : MOVE;

  state_t                    state, state_n;
  cmd_t                      cmd_q, cmd_in;
  logic [CHAR_ID_LENGTH-1:0] data_q;
  logic [ROW_BIT_LEN-1:0]    clr_row;
  logic [COL_BIT_LEN-1:0]    clr_col;
  logic                      accept, clr_step;
  pos_op_t                   pos_op;

  logic [ROW_BIT_LEN-1:0]    row;
  logic [COL_BIT_LEN-1:0]    col;
  logic                      last_row, last_col, at_origin;

  logic                      ready;
  logic                      wr_en, wr_push_up;
  logic [ROW_BIT_LEN-1:0]    wr_row;
  logic [COL_BIT_LEN-1:0]    wr_col;
  logic [CHAR_ID_LENGTH-1:0] wr_data;

  text_cursor_pos #(
    .ROW_NUMBER  (ROW_NUMBER),
    .COL_NUMBER  (COL_NUMBER),
    .ROW_BIT_LEN (ROW_BIT_LEN),
    .COL_BIT_LEN (COL_BIT_LEN)
  ) u_pos (
    .clock     (clock),
    .reset     (reset),
    .op        (pos_op),
    .row       (row),
    .col       (col),
    .last_row  (last_row),
    .last_col  (last_col),
    .at_origin (at_origin)
  );

  assign cmd_in = decode_byte(32'(bus.char_in));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_n;
  end

  // Latched command/byte and the clear-screen scan address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q   <= CMD_PRINT;
      data_q  <= '0;
      clr_row <= '0;
      clr_col <= '0;
    end else begin
      if (accept) begin
        cmd_q   <= cmd_in;
        data_q  <= bus.char_in;
        clr_row <= '0;
        clr_col <= '0;
      end else if (clr_step) begin
        if (clr_col == COL_LAST) begin
          clr_col <= '0;
          clr_row <= clr_row + ROW_BIT_LEN'(1);
        end else begin
          clr_col <= clr_col + COL_BIT_LEN'(1);
        end
      end
    end
  end

  always_comb begin
    state_n    = state;
    pos_op     = POS_HOLD;
    accept     = 1'b0;
    clr_step   = 1'b0;
    ready      = 1'b0;
    wr_en      = 1'b0;
    wr_push_up = 1'b0;
    wr_row     = '0;
    wr_col     = '0;
    wr_data    = '0;
    case (state)
      INIT: state_n = SETTLE;
      IDLE: begin
        ready = 1'b1;
        if (bus.char_valid) begin
          accept = 1'b1;
          case (cmd_in)
            CMD_LF, CMD_CR: state_n = MOVE_ENTRY;
            // Backspace at the origin has nothing to do
            CMD_BS:         state_n = at_origin ? IDLE : MOVE_ENTRY;
            CMD_FF:         state_n = CLEAR;
            default:        state_n = WRITE;
          endcase
        end
      end
      WRITE: begin
        wr_en  = 1'b1;
        wr_row = row;
        wr_col = col;
        if (cmd_q == CMD_BS) begin
          // Blanking the cell a backspace moved onto; cursor already moved
          wr_data = BLANK;
          state_n = IDLE;
        end else begin
          wr_data = data_q;
          if (last_row && last_col) begin
            pos_op  = POS_HOME_COL;
            state_n = SCROLL;
          end else begin
            pos_op  = POS_ADVANCE;
            state_n = SETTLE;
          end
        end
      end
      ERASE: begin
        wr_en   = 1'b1;
        wr_row  = row;
        wr_col  = col;
        wr_data = BLANK;
        state_n = MOVE;
      end
      MOVE: begin
        state_n = SETTLE;
        case (cmd_q)
          CMD_LF: begin
            if (last_row) begin
              pos_op  = POS_HOME_COL;
              state_n = SCROLL;
            end else begin
              pos_op  = POS_NEXT_LINE;
            end
          end
          CMD_CR: pos_op = POS_HOME_COL;
          CMD_BS: begin
            pos_op  = POS_RETREAT;
            // With the cursor glyph, DRAW overwrites the cell anyway
            state_n = CURSOR_ON ? DRAW : WRITE;
          end
          default: ;
        endcase
      end
      SCROLL: begin
        wr_en      = 1'b1;
        wr_push_up = 1'b1;
        wr_row     = ROW_LAST;
        wr_col     = '0;
        wr_data    = BLANK;
        state_n    = SETTLE;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_row  = clr_row;
        wr_col  = clr_col;
        wr_data = BLANK;
        if (clr_row == ROW_LAST && clr_col == COL_LAST) begin
          pos_op  = POS_HOME_ALL;
          state_n = SETTLE;
        end else begin
          clr_step = 1'b1;
        end
      end
      DRAW: begin
        wr_en   = 1'b1;
        wr_row  = row;
        wr_col  = col;
        wr_data = GLYPH;
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  assign bus.char_ready = ready;
  assign bus.wr_en      = wr_en;
  assign bus.wr_push_up = wr_push_up;
  assign bus.wr_row     = wr_row;
  assign bus.wr_col     = wr_col;
  assign bus.wr_data    = wr_data;
  assign bus.cursor_row = row;
  assign bus.cursor_col = col;

endmodule
